mem_port_arbiter: RTL and testbench

- Shares the two-port synchronous RAM (Multiport_Dynamic_ram) between REQ_COUNT independent requesters.
- Each cycle, grants up to PORT_COUNT requests in round-robin order, steers each granted request onto one RAM port, and blocks same-address hazards within a cycle.
- Returns read data one cycle later, tagged to the requester that issued it.
- Sits between the processor-side clients (fetch, load/store, DMA, debug) and the RAM.

---
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares a PORT_COUNT-port synchronous RAM between REQ_COUNT requesters.
//   Each cycle up to PORT_COUNT requests are granted in round-robin order
//   starting at rr_ptr. A candidate whose address matches an already granted
//   address is skipped when either access is a write, while two reads to the
//   same address are both granted. Read data (or the written word for writes)
//   comes back one cycle after the RAM registers it, as a single-cycle
//   rsp_valid pulse tagged to the issuing requester.
//
// Ports
//   clk          system clock
//   reset        asynchronous active-low reset
//   req_valid    per-requester request pending
//   req_ready    per-requester grant this cycle (transfer on valid & ready)
//   req_we       per-requester write enable (1 = write)
//   req_addr     flattened addresses, requester r at slice r
//   req_wdata    flattened write data, requester r at slice r
//   rsp_valid    per-requester one-cycle completion pulse
//   rsp_data     flattened response data, held between responses
//   mem_reset    active-high RAM reset (~reset)
//   mem_address  flattened RAM address bus, port p at slice p
//   mem_datain   flattened RAM write data bus
//   mem_write    per-port RAM write enable
//   mem_dataout  flattened RAM registered read data
module mem_port_arbiter #(
  parameter int REQ_COUNT  = 4,
  parameter int PORT_COUNT = 2,
  parameter int addr_width = 12,
  parameter int mem_width  = 12,
  parameter int ID_W       = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [REQ_COUNT-1:0]            req_valid,
  output logic [REQ_COUNT-1:0]            req_ready,
  input  logic [REQ_COUNT-1:0]            req_we,
  input  logic [REQ_COUNT*addr_width-1:0] req_addr,
  input  logic [REQ_COUNT*mem_width-1:0]  req_wdata,
  output logic [REQ_COUNT-1:0]            rsp_valid,
  output logic [REQ_COUNT*mem_width-1:0]  rsp_data,
  output logic                            mem_reset,
  output logic [PORT_COUNT*addr_width-1:0] mem_address,
  output logic [PORT_COUNT*mem_width-1:0] mem_datain,
  output logic [PORT_COUNT-1:0]           mem_write,
  input  logic [PORT_COUNT*mem_width-1:0] mem_dataout
);

  logic [ID_W-1:0]       rr_ptr;
  logic [REQ_COUNT-1:0]  grant;
  logic [PORT_COUNT-1:0] port_vld;
  logic [ID_W-1:0]       port_id [PORT_COUNT];
  logic [ID_W-1:0]       last_id;
  logic                  any_grant;

  logic [PORT_COUNT-1:0] stage_vld;
  logic [ID_W-1:0]       stage_id [PORT_COUNT];

  // Grant selection: scan from rr_ptr, filling ports 0,1,... in order.
  // Grants are suppressed while reset is asserted so nothing reaches the RAM.
  always_comb begin : grant_sel
    logic [ID_W-1:0] r;
    logic            hazard;
    logic            placed;
    grant     = '0;
    port_vld  = '0;
    last_id   = rr_ptr;
    any_grant = 1'b0;
    r         = '0;
    hazard    = 1'b0;
    placed    = 1'b0;
    for (int p = 0; p < PORT_COUNT; p++) port_id[p] = '0;
    if (reset) begin
      for (int i = 0; i < REQ_COUNT; i++) begin
        r      = rr_ptr + ID_W'(i);
        hazard = 1'b0;
        placed = 1'b0;
        if (req_valid[r]) begin
          for (int p = 0; p < PORT_COUNT; p++) begin
            if (port_vld[p] &&
                (req_addr[port_id[p]*addr_width +: addr_width] ==
                 req_addr[r*addr_width +: addr_width]) &&
                (req_we[r] || req_we[port_id[p]]))
              hazard = 1'b1;
          end
          if (!hazard) begin
            for (int p = 0; p < PORT_COUNT; p++) begin
              if (!port_vld[p] && !placed) begin
                port_vld[p] = 1'b1;
                port_id[p]  = r;
                placed      = 1'b1;
              end
            end
          end
          if (placed) begin
            grant[r]  = 1'b1;
            last_id   = r;
            any_grant = 1'b1;
          end
        end
      end
    end
  end

  assign req_ready = grant;
  assign mem_reset = ~reset;

  always_comb begin
    mem_address = '0;
    mem_datain  = '0;
    mem_write   = '0;
    for (int p = 0; p < PORT_COUNT; p++) begin
      if (port_vld[p]) begin
        mem_address[p*addr_width +: addr_width] = req_addr[port_id[p]*addr_width +: addr_width];
        mem_datain[p*mem_width +: mem_width]    = req_wdata[port_id[p]*mem_width +: mem_width];
        mem_write[p]                            = req_we[port_id[p]];
      end
    end
  end

  // Stage registers track which requester owns each port's RAM output; the
  // response registers then present that output one cycle later. A requester
  // owns at most one port per cycle, so response slices never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= '0;
      stage_vld <= '0;
      for (int p = 0; p < PORT_COUNT; p++) stage_id[p] <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      if (any_grant) rr_ptr <= last_id + ID_W'(1);
      stage_vld <= port_vld;
      for (int p = 0; p < PORT_COUNT; p++) stage_id[p] <= port_id[p];
      rsp_valid <= '0;
      for (int p = 0; p < PORT_COUNT; p++) begin
        if (stage_vld[p]) begin
          rsp_valid[stage_id[p]] <= 1'b1;
          rsp_data[stage_id[p]*mem_width +: mem_width] <= mem_dataout[p*mem_width +: mem_width];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with a behavioural two-port RAM
//   (registered read, write-before-read). Unwritten words read as ~addr.
//   Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [47:0] req_addr, req_wdata, rsp_data;
  logic        mem_reset;
  logic [23:0] mem_address, mem_datain, mem_dataout;
  logic [1:0]  mem_write;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_reset(mem_reset), .mem_address(mem_address), .mem_datain(mem_datain),
    .mem_write(mem_write), .mem_dataout(mem_dataout)
  );

  logic [11:0] ram [4096];
  logic        ram_init = 1'b0;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 4096; i++) ram[i] = ~12'(i);
      ram_init = 1'b1;
    end
    for (int p = 0; p < 2; p++)
      if (mem_write[p]) ram[mem_address[p*12 +: 12]] = mem_datain[p*12 +: 12];
    for (int p = 0; p < 2; p++)
      mem_dataout[p*12 +: 12] <= ram[mem_address[p*12 +: 12]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic v, input logic we,
                         input logic [11:0] a, input logic [11:0] d);
    req_valid[r]       = v;
    req_we[r]          = we;
    req_addr[r*12 +: 12]  = a;
    req_wdata[r*12 +: 12] = d;
  endtask

  function automatic logic [11:0] rd(input int r);
    return rsp_data[r*12 +: 12];
  endfunction

  task automatic slot();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    for (int r = 0; r < 4; r++) set_req(r, 1'b1, 1'b0, 12'h100 + 12'(r), 12'h0);

    // Reset held with all requesters valid
    slot(); slot(); #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_mem_reset", 32'(mem_reset), 32'h1);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);

    // Release: pointer 0 grants requesters 0 and 1
    slot(); reset = 1'b1; #1;
    chk("rel_ready", 32'(req_ready), 32'h3);
    chk("rel_addr_p0", 32'(mem_address[11:0]), 32'h100);
    chk("rel_addr_p1", 32'(mem_address[23:12]), 32'h101);
    chk("rel_mem_reset", 32'(mem_reset), 32'h0);
    slot(); req_valid = '0; #1;
    chk("rel_rsp_early", 32'(rsp_valid), 32'h0);
    // ptr now 2; responses for 0x100/0x101 appear
    slot();
    set_req(0, 1'b1, 1'b1, 12'h010, 12'h0A5);
    #1;
    chk("rel_rsp_valid", 32'(rsp_valid), 32'h3);
    chk("rel_rsp0", 32'(rd(0)), 32'hEFF);
    chk("rel_rsp1", 32'(rd(1)), 32'hEFE);
    // Write 0x0A5 -> 0x010 from requester 0
    chk("wr_ready", 32'(req_ready), 32'h1);
    chk("wr_mem_write", 32'(mem_write), 32'h1);
    chk("wr_addr", 32'(mem_address[11:0]), 32'h010);
    chk("wr_datain", 32'(mem_datain[11:0]), 32'h0A5);
    slot(); set_req(0, 1'b1, 1'b0, 12'h010, 12'h000); #1;
    chk("rd_ready", 32'(req_ready), 32'h1);
    chk("rd_mem_write", 32'(mem_write), 32'h0);
    chk("rd_rsp_gap", 32'(rsp_valid), 32'h0);
    slot(); req_valid = '0; #1;
    chk("wr_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("wr_rsp_data", 32'(rd(0)), 32'h0A5);
    // ptr now 1: hazard case
    slot();
    set_req(1, 1'b1, 1'b1, 12'h020, 12'h7FF);
    set_req(2, 1'b1, 1'b0, 12'h020, 12'h000);
    set_req(3, 1'b1, 1'b0, 12'h030, 12'h000);
    #1;
    chk("rd_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rd_rsp_data", 32'(rd(0)), 32'h0A5);
    chk("hold_rsp1", 32'(rd(1)), 32'hEFE);
    chk("hz_ready", 32'(req_ready), 32'hA);
    chk("hz_mem_write", 32'(mem_write), 32'h1);
    chk("hz_addr_p0", 32'(mem_address[11:0]), 32'h020);
    chk("hz_addr_p1", 32'(mem_address[23:12]), 32'h030);
    slot(); req_valid[1] = 1'b0; req_valid[3] = 1'b0; #1;
    chk("hz_retry_ready", 32'(req_ready), 32'h4);
    chk("hz_rsp_gap", 32'(rsp_valid), 32'h0);
    slot(); req_valid = '0; #1;
    chk("hz_rsp_valid", 32'(rsp_valid), 32'hA);
    chk("hz_rsp1", 32'(rd(1)), 32'h7FF);
    chk("hz_rsp3", 32'(rd(3)), 32'hFCF);
    // ptr now 3: same-address reads from 0 and 1
    slot();
    set_req(0, 1'b1, 1'b0, 12'h040, 12'h000);
    set_req(1, 1'b1, 1'b0, 12'h040, 12'h000);
    #1;
    chk("hz_rsp_valid2", 32'(rsp_valid), 32'h4);
    chk("hz_rsp2", 32'(rd(2)), 32'h7FF);
    chk("sa_ready", 32'(req_ready), 32'h3);
    slot(); req_valid = '0; #1;
    chk("sa_idle_ready", 32'(req_ready), 32'h0);
    slot();
    for (int r = 0; r < 4; r++) set_req(r, 1'b1, 1'b0, 12'h200 + 12'(r), 12'h0);
    #1;
    chk("sa_rsp_valid", 32'(rsp_valid), 32'h3);
    chk("sa_rsp0", 32'(rd(0)), 32'hFBF);
    chk("sa_rsp1", 32'(rd(1)), 32'hFBF);
    // ptr now 2: all four reading continuously
    chk("rr_ready_a", 32'(req_ready), 32'hC);
    slot(); #1;
    chk("rr_ready_b", 32'(req_ready), 32'h3);
    chk("rr_rsp_b", 32'(rsp_valid), 32'h0);
    slot(); #1;
    chk("rr_ready_c", 32'(req_ready), 32'hC);
    chk("rr_rsp_c", 32'(rsp_valid), 32'hC);
    slot(); #1;
    chk("rr_ready_d", 32'(req_ready), 32'h3);
    chk("rr_rsp_d", 32'(rsp_valid), 32'h3);
    slot(); req_valid = '0; #1;
    chk("rr_rsp_e", 32'(rsp_valid), 32'hC);
    chk("rr_rsp3", 32'(rd(3)), 32'hDFC);
    // ptr now 2: mid-flight reset
    slot();
    set_req(0, 1'b1, 1'b0, 12'h300, 12'h0);
    set_req(1, 1'b1, 1'b0, 12'h301, 12'h0);
    #1;
    chk("rr_rsp_f", 32'(rsp_valid), 32'h3);
    chk("rr_rsp0", 32'(rd(0)), 32'hDFF);
    chk("mf_ready", 32'(req_ready), 32'h3);
    slot(); req_valid = '0; reset = 1'b0; #1;
    chk("mf_rsp_rst", 32'(rsp_valid), 32'h0);
    chk("mf_data_rst", 32'(rd(2)), 32'h0);
    slot(); reset = 1'b1; #1;
    chk("mf_rsp_dropped", 32'(rsp_valid), 32'h0);
    slot(); #1;
    chk("mf_rsp_dropped2", 32'(rsp_valid), 32'h0);
    req_valid = 4'hF; #1;
    chk("mf_ptr_zero", 32'(req_ready), 32'h3);
    slot(); req_valid = '0;
    slot();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
